card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 154 +++++++++++++++
 tb/tb_card_dealer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card dealer: draws cards from a 52-card deck without replacement. The start slot comes
// from a free-running 6-bit LFSR; a linear scan then finds the next undealt slot.
module card_dealer (
    input  logic       clk,
    input  logic       rst,
    input  logic       pip,
    input  logic       new_game,
    output logic [3:0] number,
    output logic       number_valid,
    output logic       busy,
    output logic       deck_empty,
    output logic [5:0] cards_left
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  lfsr_q, lfsr_d;
    logic [5:0]  idx_q, idx_d;
    logic [51:0] mask_q, mask_d;
    logic [3:0]  number_q, number_d;
    logic        number_valid_q, number_valid_d;
    logic        busy_q, busy_d;
    logic        deck_empty_q, deck_empty_d;
    logic [5:0]  cards_left_q, cards_left_d;

    logic [5:0]  start_idx_s;
    logic [5:0]  next_idx_s;
    logic        slot_free_s;
    logic        draw_req_s;

    // LFSR step, start-slot folding and scan helpers
    always_comb begin
        lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        if (lfsr_q <= 6'd52) begin
            start_idx_s = lfsr_q - 6'd1;
        end else begin
            start_idx_s = lfsr_q - 6'd53;
        end
        if (idx_q == 6'd51) begin
            next_idx_s = 6'd0;
        end else begin
            next_idx_s = idx_q + 6'd1;
        end
        slot_free_s = ~mask_q[idx_q];
        draw_req_s  = pip & ~deck_empty_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; new_game always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (draw_req_s) begin
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    if (slot_free_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SCAN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output and datapath logic
    always_comb begin
        mask_d         = mask_q;
        idx_d          = idx_q;
        number_d       = number_q;
        number_valid_d = 1'b0;
        cards_left_d   = cards_left_q;
        if (new_game) begin
            mask_d       = 52'd0;
            cards_left_d = 6'd52;
        end else begin
            case (state_q)
                IDLE: begin
                    if (draw_req_s) begin
                        idx_d = start_idx_s;
                    end else begin
                        idx_d = idx_q;
                    end
                end
                SCAN: begin
                    if (slot_free_s) begin
                        mask_d         = mask_q | (52'd1 << idx_q);
                        number_d       = idx_q[5:2] + 4'd1;
                        number_valid_d = 1'b1;
                        cards_left_d   = cards_left_q - 6'd1;
                    end else begin
                        idx_d = next_idx_s;
                    end
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end
        busy_d       = (state_d == SCAN);
        deck_empty_d = (cards_left_d == 6'd0);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q         <= 6'b000001;
            idx_q          <= 6'd0;
            mask_q         <= 52'd0;
            number_q       <= 4'd0;
            number_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            deck_empty_q   <= 1'b0;
            cards_left_q   <= 6'd52;
        end else begin
            lfsr_q         <= lfsr_d;
            idx_q          <= idx_d;
            mask_q         <= mask_d;
            number_q       <= number_d;
            number_valid_q <= number_valid_d;
            busy_q         <= busy_d;
            deck_empty_q   <= deck_empty_d;
            cards_left_q   <= cards_left_d;
        end
    end

    assign number       = number_q;
    assign number_valid = number_valid_q;
    assign busy         = busy_q;
    assign deck_empty   = deck_empty_q;
    assign cards_left   = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a draw-level deck model predicts every output each
// cycle, and directed scenarios pin reset, wrap-around, exhaustion and new_game behaviour.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst, pip, new_game;
    logic [3:0] number;
    logic       number_valid, busy, deck_empty;
    logic [5:0] cards_left;

    card_dealer dut (
        .clk(clk), .rst(rst), .pip(pip), .new_game(new_game),
        .number(number), .number_valid(number_valid), .busy(busy),
        .deck_empty(deck_empty), .cards_left(cards_left)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Deck model: a draw is resolved completely when it is accepted
    bit used [52];
    int m_lfsr, m_number, m_cards, m_left, m_slot;
    bit m_valid, m_busy, m_empty, m_pend, armed;
    int val_count [16];
    int pulses = 0;
    int last_valid_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int step_lfsr(input int v);
        int fb;
        fb = ((v >> 5) ^ (v >> 4)) & 1;
        return ((v << 1) & 63) | fb;
    endfunction

    function automatic int start_of(input int l);
        return (l <= 52) ? (l - 1) : (l - 53);
    endfunction

    function automatic int find_slot(input int s);
        for (int k = 0; k < 52; k++) begin
            if (!used[(s + k) % 52]) return (s + k) % 52;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare DUT against the model, then advance the model with this cycle's inputs
    initial begin
        int nl, st;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (armed) begin
                check("number_valid", number_valid, m_valid);
                check("busy", busy, m_busy);
                check("cards_left", cards_left, m_cards);
                check("deck_empty", deck_empty, m_empty);
                check("number", number, m_number);
                if (number_valid) begin
                    pulses++;
                    val_count[number]++;
                    last_valid_cyc = cyc;
                end
            end
            if (rst) begin
                foreach (used[i]) used[i] = 1'b0;
                m_lfsr = 1; m_number = 0; m_cards = 52;
                m_valid = 0; m_busy = 0; m_empty = 0; m_pend = 0;
                armed = 1'b1;
            end else begin
                nl = step_lfsr(m_lfsr);
                m_valid = 0;
                if (new_game) begin
                    foreach (used[i]) used[i] = 1'b0;
                    m_cards = 52; m_empty = 0; m_pend = 0; m_busy = 0;
                end else if (m_pend) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid  = 1;
                        m_number = m_slot / 4 + 1;
                        m_cards--;
                        m_empty  = (m_cards == 0);
                        m_busy   = 0;
                        m_pend   = 0;
                    end
                end else if (pip && m_cards != 0) begin
                    st     = start_of(m_lfsr);
                    m_slot = find_slot(st);
                    used[m_slot] = 1'b1;
                    m_left = ((m_slot - st + 52) % 52) + 1;
                    m_pend = 1;
                    m_busy = 1;
                end
                m_lfsr = nl;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        foreach (val_count[i]) val_count[i] = 0;
        pulses = 0;
    endtask

    // Pulse pip for one cycle (optionally only when the draw cannot land on slot 0) and wait for the card
    task automatic draw_one(input bit avoid_zero);
        bit seen;
        for (int i = 0; i < 200; i++) begin
            if (!avoid_zero || find_slot(start_of(m_lfsr)) != 0) break;
            tick();
        end
        pip = 1'b1;
        tick();
        pip = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (number_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("draw_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int t0, saved, quiet;
        bit found;
        rst = 1'b1; pip = 1'b0; new_game = 1'b0;
        repeat (3) tick();

        // Reset values
        @(negedge clk);
        check("rst_number", number, 0);
        check("rst_valid", number_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", deck_empty, 0);
        check("rst_cards", cards_left, 52);
        tick();

        // First draw right after reset release: lfsr=1 -> slot 0 -> value 1
        rst = 1'b0; pip = 1'b1; t0 = cyc;
        tick();
        pip = 1'b0;
        @(negedge clk);
        check("first_busy_c1", busy, 1);
        check("first_valid_c1", number_valid, 0);
        tick();
        @(negedge clk);
        check("first_valid_c2", number_valid, 1);
        check("first_number", number, 1);
        check("first_cards", cards_left, 51);
        check("first_busy_c2", busy, 0);
        check("first_latency", cyc - t0, 2);
        tick();

        // new_game during SCAN aborts the draw and keeps number
        saved = number;
        pip = 1'b1;
        tick();
        pip = 1'b0; new_game = 1'b1;
        @(negedge clk);
        check("ng_scan_busy", busy, 1);
        tick();
        new_game = 1'b0;
        @(negedge clk);
        check("ng_busy", busy, 0);
        check("ng_valid", number_valid, 0);
        check("ng_cards", cards_left, 52);
        check("ng_number", number, saved);
        tick();
        @(negedge clk);
        check("ng_valid_late", number_valid, 0);
        tick();

        // pip together with new_game at 40 cards left: reload, no draw
        for (int i = 0; i < 12; i++) draw_one(1'b0);
        @(negedge clk);
        check("cards_40", cards_left, 40);
        tick();
        pip = 1'b1; new_game = 1'b1;
        tick();
        pip = 1'b0; new_game = 1'b0;
        @(negedge clk);
        check("pipng_cards", cards_left, 52);
        check("pipng_busy", busy, 0);
        tick();
        @(negedge clk);
        check("pipng_valid", number_valid, 0);
        tick();

        // rst in the middle of a draw
        pip = 1'b1;
        tick();
        pip = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", number_valid, 0);
        check("rstmid_number", number, 0);
        check("rstmid_cards", cards_left, 52);
        tick();

        // Exhaust the deck leaving slot 0 for last, then draw it through a 51->0 wrap
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        clear_counts();
        for (int i = 0; i < 51; i++) draw_one(1'b1);
        @(negedge clk);
        check("cards_1", cards_left, 1);
        tick();
        found = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (m_lfsr == 52) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("lfsr52_found", found, 1);
        pip = 1'b1; t0 = cyc;
        tick();
        pip = 1'b0;
        repeat (3) @(negedge clk);
        check("wrap_valid", number_valid, 1);
        check("wrap_number", number, 1);
        check("wrap_latency", last_valid_cyc - t0, 3);
        check("wrap_cards", cards_left, 0);
        check("wrap_empty", deck_empty, 1);
        check("deck_pulses", pulses, 52);
        for (int v = 1; v <= 13; v++) check($sformatf("deck_value_%0d", v), val_count[v], 4);
        tick();

        // 53rd request on an empty deck gives nothing
        quiet = pulses;
        pip = 1'b1;
        tick();
        pip = 1'b0;
        repeat (60) @(negedge clk);
        check("empty_no_pulse", pulses - quiet, 0);
        check("empty_still", deck_empty, 1);
        tick();

        // pip held high: one draw per IDLE visit, no duplicates, until empty
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        clear_counts();
        pip = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (deck_empty) begin
                found = 1'b1;
                break;
            end
        end
        check("held_drained", found, 1);
        check("held_pulses", pulses, 52);
        for (int v = 1; v <= 13; v++) check($sformatf("held_value_%0d", v), val_count[v], 4);
        quiet = pulses;
        repeat (20) @(negedge clk);
        check("held_empty_no_pulse", pulses - quiet, 0);
        tick();
        pip = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
